// File: rtl/gray_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_pkg
//  Description : Shared width default and Gray-step helper for gray_counter.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_counter_pkg;

    localparam int GRAY_LEN_DEF = 4;

    // True when exactly one bit of v is set (callers zero-extend to 32 bits).
    function automatic logic is_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage : gray_counter_pkg
`default_nettype wire

// File: rtl/gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_if
//  Description : Control and count bundle between a driver and gray_counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_counter_if
    import gray_counter_pkg::*;
#(
    parameter int LEN = GRAY_LEN_DEF
);
    logic           en;
    logic           up;
    logic           load;
    logic [LEN-1:0] load_val;
    logic [LEN-1:0] bin_out;
    logic [LEN-1:0] gray_out;
    logic           wrap;
    logic           step_err;

    modport master (
        output en, up, load, load_val,
        input  bin_out, gray_out, wrap, step_err
    );

    modport slave (
        input  en, up, load, load_val,
        output bin_out, gray_out, wrap, step_err
    );
endinterface : gray_counter_if
`default_nettype wire

// File: rtl/gray_counter_binary_to_gray.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_gray
//  Description : Combinational binary to reflected-Gray conversion.
//  Revision    : 1.0  initial release
// ============================================================================
module binary_to_gray
    import gray_counter_pkg::*;
#(
    parameter int LEN = GRAY_LEN_DEF
) (
    input  wire logic [LEN-1:0] i_bin,
    output logic      [LEN-1:0] o_gray
);
    assign o_gray = i_bin ^ (i_bin >> 1);
endmodule : binary_to_gray
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Up/down binary counter with registered Gray output, wrap
//                pulse and sticky single-bit-step checker.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int LEN = GRAY_LEN_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    gray_counter_if.slave bus
);
    localparam logic [LEN-1:0] c_one = {{(LEN-1){1'b0}}, 1'b1};
    localparam logic [LEN-1:0] c_max = {LEN{1'b1}};
    localparam logic [LEN-1:0] c_zero = {LEN{1'b0}};

    logic [LEN-1:0] r_bin;
    logic [LEN-1:0] r_gray;
    logic           r_wrap;
    logic           r_err;

    logic [LEN-1:0] w_next;
    logic [LEN-1:0] w_next_gray;
    logic [LEN-1:0] w_diff;
    logic           w_wrap;
    logic           w_step;
    logic           w_step_bad;

    // Load beats counting; a load is not a step, so the checker ignores it.
    always_comb begin
        w_next = r_bin;
        w_wrap = 1'b0;
        w_step = 1'b0;
        if (bus.load) begin
            w_next = bus.load_val;
        end else if (bus.en) begin
            w_step = 1'b1;
            if (bus.up) begin
                w_next = r_bin + c_one;
                w_wrap = (r_bin == c_max);
            end else begin
                w_next = r_bin - c_one;
                w_wrap = (r_bin == c_zero);
            end
        end
    end

    binary_to_gray #(
        .LEN (LEN)
    ) u_b2g (
        .i_bin  (w_next),
        .o_gray (w_next_gray)
    );

    assign w_diff     = w_next_gray ^ r_gray;
    assign w_step_bad = w_step && !is_one_hot(32'(w_diff));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_bin  <= w_next;
            r_gray <= w_next_gray;
            r_wrap <= w_wrap;
            if (w_step_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.bin_out  = r_bin;
    assign bus.gray_out = r_gray;
    assign bus.wrap     = r_wrap;
    assign bus.step_err = r_err;

endmodule : gray_counter
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Self-checking bench for gray_counter against a modulo model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter;
    localparam int LEN = 4;
    localparam int MOD = 1 << LEN;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    int m_bin  = 0;
    bit m_wrap = 1'b0;
    bit m_err  = 1'b0;

    gray_counter_if #(.LEN(LEN)) bus ();

    gray_counter #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain modulo arithmetic on an integer count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bin  <= 0;
            m_wrap <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            if (bus.load) begin
                m_bin  <= int'(bus.load_val);
                m_wrap <= 1'b0;
            end else if (bus.en) begin
                int nb;
                nb = bus.up ? (m_bin + 1) % MOD : (m_bin + MOD - 1) % MOD;
                m_bin  <= nb;
                m_wrap <= bus.up ? (m_bin == MOD - 1) : (m_bin == 0);
                if ($countones(to_gray(nb) ^ to_gray(m_bin)) != 1) m_err <= 1'b1;
            end else begin
                m_wrap <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("bin_out",  int'(bus.bin_out),  m_bin);
            chk("gray_out", int'(bus.gray_out), to_gray(m_bin));
            chk("gray_rel", int'(bus.gray_out), int'(bus.bin_out ^ (bus.bin_out >> 1)));
            chk("wrap",     int'(bus.wrap),     int'(m_wrap));
            chk("step_err", int'(bus.step_err), int'(m_err));
        end
    end

    task automatic drive(input bit e, input bit u, input bit l, input int v);
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = LEN'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_g [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_bin",  int'(bus.bin_out),  0);
        chk("reset_gray", int'(bus.gray_out), 0);

        // Full up sweep from 0.
        drive(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("sweep_gray", int'(bus.gray_out), exp_g[i]);
            chk("sweep_wrap", int'(bus.wrap), (i == 15) ? 1 : 0);
        end

        // Down from 0 wraps to F.
        drive(1, 0, 0, 0);
        tick();
        chk("down_bin",  int'(bus.bin_out),  15);
        chk("down_gray", int'(bus.gray_out), 8);
        chk("down_wrap", int'(bus.wrap),     1);
        tick();
        chk("down2_bin",  int'(bus.bin_out),  14);
        chk("down2_gray", int'(bus.gray_out), 9);
        chk("down2_wrap", int'(bus.wrap),     0);

        // Load has priority over an increment.
        drive(1, 1, 1, 5);
        tick();
        chk("load_bin",  int'(bus.bin_out),  5);
        chk("load_gray", int'(bus.gray_out), 7);
        chk("load_wrap", int'(bus.wrap),     0);
        chk("load_err",  int'(bus.step_err), 0);

        // Hold at A.
        drive(0, 1, 1, 10);
        tick();
        drive(0, 0, 0, 0);
        repeat (5) begin
            tick();
            chk("hold_bin",  int'(bus.bin_out),  10);
            chk("hold_gray", int'(bus.gray_out), 15);
            chk("hold_wrap", int'(bus.wrap),     0);
        end

        // Asynchronous reset between clock edges.
        drive(0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 0);
        chk("pre_rst_bin", int'(bus.bin_out), 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_bin",  int'(bus.bin_out),  0);
        chk("arst_gray", int'(bus.gray_out), 0);
        chk("arst_wrap", int'(bus.wrap),     0);
        chk("arst_err",  int'(bus.step_err), 0);
        tick();
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0,
                  int'($urandom % MOD));
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        chk("final_err", int'(bus.step_err), 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_gray_counter
`default_nettype wire
